// File: rtl/hub75_scan_ctrl.sv
// HUB75 1bpp scan sequencer: walks framebuffer addresses, shifts six colour bits per column,
// then blanks, latches and displays one scan row at a time.
module hub75_scan_ctrl #(
  parameter int COLS         = 64,
  parameter int ROWS         = 32,
  parameter int CLK_HALF     = 1,
  parameter int LAT_CYCLES   = 1,
  parameter int BLANK_CYCLES = 2,
  parameter int ON_CYCLES    = 256,
  localparam int COL_W       = $clog2(COLS),
  localparam int ROW_W       = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic [COL_W-1:0] fb_col,
  output logic [ROW_W-1:0] fb_row,
  output logic             fb_rd,
  input  logic [5:0]       rgb_in,
  output logic [5:0]       rgb_out,
  output logic             panel_clk,
  output logic             panel_lat,
  output logic             panel_oe_n,
  output logic [ROW_W-1:0] row_addr,
  output logic             frame_done
);

  localparam int MAX_AB  = (CLK_HALF > LAT_CYCLES) ? CLK_HALF : LAT_CYCLES;
  localparam int MAX_CD  = (BLANK_CYCLES > ON_CYCLES) ? BLANK_CYCLES : ON_CYCLES;
  localparam int MAX_CNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, HIGH, BLANK, LATCH, SHOW
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [COL_W-1:0] fb_col_q, fb_col_d;
  logic [ROW_W-1:0] fb_row_q, fb_row_d;
  logic [ROW_W-1:0] row_addr_q, row_addr_d;
  logic [5:0]       rgb_q, rgb_d;
  logic             fb_rd_q, fb_rd_d;
  logic             panel_clk_q, panel_clk_d;
  logic             panel_lat_q, panel_lat_d;
  logic             panel_oe_n_q, panel_oe_n_d;
  logic             frame_done_q, frame_done_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fb_col_d     = fb_col_q;
    fb_row_d     = fb_row_q;
    row_addr_d   = row_addr_q;
    rgb_d        = rgb_q;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d  = FETCH;
          fb_col_d = '0;
        end
      end
      FETCH: begin
        state_d = LOAD;
        cnt_d   = CNT_W'(CLK_HALF - 1);
      end
      LOAD: begin
        // Read data arrives one cycle after the strobe, i.e. in the first LOAD cycle.
        if (cnt_q == CNT_W'(CLK_HALF - 1)) rgb_d = rgb_in;
        if (cnt_q == '0) begin
          state_d = HIGH;
          cnt_d   = CNT_W'(CLK_HALF - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HIGH: begin
        if (cnt_q == '0) begin
          if (fb_col_q == COL_W'(COLS - 1)) begin
            state_d    = BLANK;
            cnt_d      = CNT_W'(BLANK_CYCLES - 1);
            row_addr_d = fb_row_q;
          end else begin
            state_d  = FETCH;
            fb_col_d = fb_col_q + COL_W'(1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      BLANK: begin
        if (cnt_q == '0) begin
          state_d = LATCH;
          cnt_d   = CNT_W'(LAT_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      LATCH: begin
        if (cnt_q == '0) begin
          state_d = SHOW;
          cnt_d   = CNT_W'(ON_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SHOW: begin
        if (cnt_q == '0) begin
          fb_col_d = '0;
          state_d  = enable ? FETCH : IDLE;
          if (fb_row_q == ROW_W'(ROWS - 1)) begin
            fb_row_d     = '0;
            frame_done_d = 1'b1;
          end else begin
            fb_row_d = fb_row_q + ROW_W'(1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Panel strobes are decoded from the next state so they line up with the state register.
    fb_rd_d      = (state_d == FETCH);
    panel_clk_d  = (state_d == HIGH);
    panel_lat_d  = (state_d == LATCH);
    panel_oe_n_d = (state_d != SHOW);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      fb_col_q     <= '0;
      fb_row_q     <= '0;
      row_addr_q   <= '0;
      rgb_q        <= '0;
      fb_rd_q      <= 1'b0;
      panel_clk_q  <= 1'b0;
      panel_lat_q  <= 1'b0;
      panel_oe_n_q <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fb_col_q     <= fb_col_d;
      fb_row_q     <= fb_row_d;
      row_addr_q   <= row_addr_d;
      rgb_q        <= rgb_d;
      fb_rd_q      <= fb_rd_d;
      panel_clk_q  <= panel_clk_d;
      panel_lat_q  <= panel_lat_d;
      panel_oe_n_q <= panel_oe_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign fb_col     = fb_col_q;
  assign fb_row     = fb_row_q;
  assign fb_rd      = fb_rd_q;
  assign rgb_out    = rgb_q;
  assign panel_clk  = panel_clk_q;
  assign panel_lat  = panel_lat_q;
  assign panel_oe_n = panel_oe_n_q;
  assign row_addr   = row_addr_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Bench for hub75_scan_ctrl: two instances (CLK_HALF=1 and 3) checked every cycle against a
// row-phase model computed arithmetically from the scan timing rules.
module tb_hub75_scan_ctrl;
  localparam int COLS = 4, ROWS = 2, LATC = 1, BLANKC = 2, ONC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, enable;
  logic [5:0] rgb_in [2];
  logic [1:0] fb_col_o [2];
  logic [0:0] fb_row_o [2];
  logic [0:0] row_addr_o [2];
  logic       fb_rd_o [2], clk_o [2], lat_o [2], oe_n_o [2], fd_o [2];
  logic [5:0] rgb_o [2];

  hub75_scan_ctrl #(.COLS(COLS), .ROWS(ROWS), .CLK_HALF(1), .LAT_CYCLES(LATC),
                    .BLANK_CYCLES(BLANKC), .ON_CYCLES(ONC)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fb_col(fb_col_o[0]), .fb_row(fb_row_o[0]),
    .fb_rd(fb_rd_o[0]), .rgb_in(rgb_in[0]), .rgb_out(rgb_o[0]), .panel_clk(clk_o[0]),
    .panel_lat(lat_o[0]), .panel_oe_n(oe_n_o[0]), .row_addr(row_addr_o[0]),
    .frame_done(fd_o[0]));

  hub75_scan_ctrl #(.COLS(COLS), .ROWS(ROWS), .CLK_HALF(3), .LAT_CYCLES(LATC),
                    .BLANK_CYCLES(BLANKC), .ON_CYCLES(ONC)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fb_col(fb_col_o[1]), .fb_row(fb_row_o[1]),
    .fb_rd(fb_rd_o[1]), .rgb_in(rgb_in[1]), .rgb_out(rgb_o[1]), .panel_clk(clk_o[1]),
    .panel_lat(lat_o[1]), .panel_oe_n(oe_n_o[1]), .row_addr(row_addr_o[1]),
    .frame_done(fd_o[1]));

  logic [5:0] pix [ROWS][COLS];
  int errors = 0, checks = 0;

  bit         m_idle [2];
  int         m_ph [2], m_row [2], m_raddr [2];
  logic [5:0] m_rgb [2];
  bit         m_fd [2];

  logic       prev_rd [2];
  logic [1:0] prev_col [2];
  logic [0:0] prev_row [2];

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int half_of(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // One row = COLS column slots of (1 + 2*half) cycles, then blank, latch, show.
  task automatic model_step(int d);
    int cp = 1 + 2 * half_of(d);
    int s  = COLS * cp;
    int p  = s + BLANKC + LATC + ONC;
    if (!rst_n) begin
      m_idle[d] = 1; m_ph[d] = 0; m_row[d] = 0; m_raddr[d] = 0; m_rgb[d] = '0; m_fd[d] = 0;
    end else begin
      m_fd[d] = 0;
      if (m_idle[d]) begin
        if (enable) begin m_idle[d] = 0; m_ph[d] = 0; end
      end else begin
        if (m_ph[d] == p - 1) begin
          m_fd[d]  = (m_row[d] == ROWS - 1);
          m_row[d] = (m_row[d] + 1) % ROWS;
          m_ph[d]  = 0;
          if (!enable) m_idle[d] = 1;
        end else begin
          m_ph[d]++;
        end
        if (!m_idle[d]) begin
          if (m_ph[d] < s && (m_ph[d] % cp) == 2) m_rgb[d] = pix[m_row[d]][m_ph[d] / cp];
          if (m_ph[d] == s) m_raddr[d] = m_row[d];
        end
      end
    end
  endtask

  function automatic logic [14:0] exp_vec(int d);
    int   cp = 1 + 2 * half_of(d);
    int   s  = COLS * cp;
    int   col = 0, r;
    logic rd = 0, pc = 0, lt = 0, oe = 1;
    if (!m_idle[d]) begin
      if (m_ph[d] < s) begin
        col = m_ph[d] / cp;
        rd  = (m_ph[d] % cp) == 0;
        pc  = (m_ph[d] % cp) > half_of(d);
      end else begin
        col = COLS - 1;
        r   = m_ph[d] - s;
        lt  = (r >= BLANKC) && (r < BLANKC + LATC);
        oe  = (r < BLANKC + LATC);
      end
    end
    return {m_fd[d], rd, pc, lt, oe, 2'(col), 1'(m_row[d]), 1'(m_raddr[d]), m_rgb[d]};
  endfunction

  function automatic logic [14:0] act_vec(int d);
    return {fd_o[d], fb_rd_o[d], clk_o[d], lat_o[d], oe_n_o[d], fb_col_o[d], fb_row_o[d],
            row_addr_o[d], rgb_o[d]};
  endfunction

  // Framebuffer/extractor stand-in: data for the address read last cycle, noise otherwise.
  task automatic drive_rgb();
    for (int d = 0; d < 2; d++) begin
      rgb_in[d]   = prev_rd[d] ? pix[prev_row[d]][prev_col[d]] : 6'($urandom);
      prev_rd[d]  = fb_rd_o[d];
      prev_col[d] = fb_col_o[d];
      prev_row[d] = fb_row_o[d];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq(d == 0 ? "outs_a" : "outs_b", 32'(act_vec(d)), 32'(exp_vec(d)));
      check_eq(d == 0 ? "oe_lat_a" : "oe_lat_b", 32'(!oe_n_o[d] && lat_o[d]), 0);
      check_eq(d == 0 ? "lat_clk_a" : "lat_clk_b", 32'(lat_o[d] && clk_o[d]), 0);
    end
    drive_rgb();
  endtask

  initial begin
    int  rises, nrd;
    bit  found;
    logic prevc;

    rst_n = 1'b0; enable = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rgb_in[d] = '0; prev_rd[d] = 0; prev_col[d] = '0; prev_row[d] = '0;
      m_idle[d] = 1; m_ph[d] = 0; m_row[d] = 0; m_raddr[d] = 0; m_rgb[d] = '0; m_fd[d] = 0;
    end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) pix[r][c] = 6'(c);

    repeat (3) tick();
    check_eq("rst_oe_n", 32'(oe_n_o[0]), 1);
    check_eq("rst_outs", 32'({fd_o[0], fb_rd_o[0], clk_o[0], lat_o[0], fb_col_o[0], fb_row_o[0],
                              row_addr_o[0], rgb_o[0]}), 0);

    rst_n = 1'b1;
    tick();
    check_eq("first_fetch", 32'({fb_rd_o[0], fb_col_o[0]}), 32'b100);

    rises = 0; prevc = clk_o[0];
    for (int i = 1; i <= 38; i++) begin
      tick();
      if (i <= 18 && clk_o[0] && !prevc) begin
        rises++;
        check_eq("rgb_at_rise", 32'(rgb_o[0]), 32'(rises - 1));
      end
      if (i == 19) check_eq("row1_start", 32'({fb_rd_o[0], fb_row_o[0]}), 32'b11);
      prevc = clk_o[0];
    end
    check_eq("clk_rises_row0", 32'(rises), COLS);
    check_eq("frame_done", 32'(fd_o[0]), 1);
    check_eq("row_wrap", 32'(fb_row_o[0]), 0);

    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (fb_col_o[0] == 2'd1) found = 1;
    end
    check_eq("wait_col1", 32'(found), 1);
    enable = 1'b0;
    repeat (40) tick();
    nrd = 0;
    repeat (10) begin
      tick();
      nrd += int'(fb_rd_o[0]) + int'(fb_rd_o[1]);
    end
    check_eq("idle_no_rd", 32'(nrd), 0);
    check_eq("idle_oe_n", 32'(oe_n_o[0]), 1);

    enable = 1'b1;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (clk_o[0] && fb_col_o[0] == 2'd2) found = 1;
    end
    check_eq("wait_col2_high", 32'(found), 1);
    rst_n = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) pix[r][c] = 6'($urandom);
    tick();
    check_eq("midrst_outs", 32'({fb_rd_o[0], clk_o[0], lat_o[0], fb_col_o[0], rgb_o[0]}), 0);
    check_eq("midrst_oe_n", 32'(oe_n_o[0]), 1);
    rst_n = 1'b1;
    tick();
    check_eq("restart", 32'({fb_rd_o[0], fb_col_o[0], fb_row_o[0]}), 32'b1000);

    for (int seg = 0; seg < 40; seg++) begin
      enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        rst_n = 1'b0;
        repeat ($urandom_range(1, 2)) tick();
        rst_n = 1'b1;
      end
      repeat ($urandom_range(5, 60)) tick();
    end
    enable = 1'b1;
    repeat (100) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
